// File: rtl/lcd_pixel_feeder.sv
// LCD pixel feeder: buffers upstream pixels in a FIFO and hands one out per LCD
// data-enable, tracking frame position so SOF misalignment is detected and recovered.
module lcd_pixel_feeder #(
   parameter int unsigned DEPTH    = 64,
   parameter int unsigned H_ACTIVE = 20,
   parameter int unsigned V_ACTIVE = 20
) (
   input  logic                     clk,
   input  logic                     areset,
   input  logic                     i_pix_valid,
   input  logic [23:0]              i_pix_data,
   input  logic                     i_pix_sof,
   output logic                     o_pix_ready,
   input  logic                     i_frame_start,
   input  logic                     i_req,
   output logic [7:0]               o_red,
   output logic [7:0]               o_green,
   output logic [7:0]               o_blue,
   output logic                     o_underrun,
   output logic                     o_desync,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int unsigned RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

   typedef struct packed {
      logic        sof;
      logic [23:0] rgb;
   } pix_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      RESYNC = 2'd2
   } state_t;

   pix_t            mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [LW-1:0]   count;
   logic            full;
   logic            empty;
   logic            wr_en;
   logic            pop;
   pix_t            head;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   col;
   logic [CW-1:0]   col_nxt;
   logic [RW-1:0]   row;
   logic [RW-1:0]   row_nxt;
   logic            at_origin;
   logic [23:0]     pix_rgb;
   logic [23:0]     rgb_nxt;
   logic            rgb_load;
   logic            set_underrun;
   logic            set_desync;

   assign full        = (count == LW'(DEPTH));
   assign empty       = (count == '0);
   assign o_pix_ready = !full;
   assign wr_en       = i_pix_valid && !full;
   assign head        = mem[rd_ptr];
   assign at_origin   = (col == '0) && (row == '0);
   assign o_level     = count;
   assign o_red       = pix_rgb[23:16];
   assign o_green     = pix_rgb[15:8];
   assign o_blue      = pix_rgb[7:0];

   // Storage array carries no reset; validity is tracked by count/pointers.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= '{sof: i_pix_sof, rgb: i_pix_data};
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + LW'(wr_en) - LW'(pop);
      end
   end

   // Next-state, position tracking, pop decision and output pixel selection.
   always_comb begin
      state_nxt    = state;
      col_nxt      = col;
      row_nxt      = row;
      pop          = 1'b0;
      rgb_load     = 1'b0;
      rgb_nxt      = '0;
      set_underrun = 1'b0;
      set_desync   = 1'b0;

      unique case (state)
         IDLE: begin
            if (i_frame_start) begin
               state_nxt = RUN;
               col_nxt   = '0;
               row_nxt   = '0;
            end
         end

         RUN: begin
            if (i_frame_start && !at_origin) begin
               set_desync = 1'b1;
               state_nxt  = RESYNC;
               col_nxt    = '0;
               row_nxt    = '0;
            end else if (i_req) begin
               rgb_load = 1'b1;
               if (!empty) begin
                  pop     = 1'b1;
                  rgb_nxt = head.rgb;
                  if (head.sof != at_origin) begin
                     set_desync = 1'b1;
                     state_nxt  = RESYNC;
                  end
               end else begin
                  set_underrun = 1'b1;
               end
               if (col == CW'(H_ACTIVE - 1)) begin
                  col_nxt = '0;
                  row_nxt = (row == RW'(V_ACTIVE - 1)) ? '0 : row + RW'(1);
               end else begin
                  col_nxt = col + CW'(1);
               end
            end
         end

         RESYNC: begin
            // Flush until an SOF pixel sits at the head, then wait for frame start.
            if (i_req) begin
               rgb_load = 1'b1;
            end
            if (!empty) begin
               if (!head.sof) begin
                  pop = 1'b1;
               end else if (i_frame_start) begin
                  state_nxt = RUN;
                  col_nxt   = '0;
                  row_nxt   = '0;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         pix_rgb    <= '0;
         o_underrun <= 1'b0;
         o_desync   <= 1'b0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         row   <= row_nxt;
         if (rgb_load) begin
            pix_rgb <= rgb_nxt;
         end
         // Frame start clears the sticky flags, but a same-cycle set wins.
         if (i_frame_start) begin
            o_underrun <= set_underrun;
            o_desync   <= set_desync;
         end else begin
            if (set_underrun) begin
               o_underrun <= 1'b1;
            end
            if (set_desync) begin
               o_desync <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/lcd_pixel_feeder.md
LCD_PIXEL_FEEDER -- requirements
Module: lcd_pixel_feeder

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set pixel FIFO entries (power of two, >=4).
REQ-002 Parameter H_ACTIVE, default 20, SHALL set pixels per line.
REQ-003 Parameter V_ACTIVE, default 20, SHALL set lines per frame.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 areset  in  1  asynchronous, active-high reset.
REQ-006 i_pix_valid  in  1  upstream pixel valid.
REQ-007 i_pix_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}.
REQ-008 i_pix_sof  in  1  marks first pixel of a frame; travels with the pixel.
REQ-009 o_pix_ready  out  1  SHALL equal !full, combinational from FIFO count.
REQ-010 i_frame_start  in  1  one-cycle pulse from the LCD controller at frame start.
REQ-011 i_req  in  1  LCD controller consumes one pixel this cycle (its data-enable).
REQ-012 o_red, o_green, o_blue  out  8 each  registered pixel to the LCD controller.
REQ-013 o_underrun  out  1  sticky: i_req seen with FIFO empty in RUN.
REQ-014 o_desync  out  1  sticky: SOF misalignment detected.
REQ-015 o_level  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Write SHALL occur when i_pix_valid && o_pix_ready; data and sof bit stored together.
REQ-017 Full and i_req in the same cycle: write SHALL NOT occur (ready is low); pop proceeds.
REQ-018 Empty with write and i_req in the same cycle: no bypass; counts as empty read.
REQ-019 States: IDLE, RUN, RESYNC; reset state IDLE.
REQ-020 IDLE: i_req ignored, RGB held at 0, no pops; i_frame_start -> RUN with col=row=0.
REQ-021 RUN, i_req, FIFO non-empty: pop head; RGB SHALL present the popped pixel on the cycle after i_req (latency 1).
REQ-022 RUN, i_req, FIFO empty: no pop, RGB SHALL be 0x000000 next cycle, o_underrun set.
REQ-023 col SHALL increment on every RUN i_req (pop or underrun); at H_ACTIVE-1 wraps to 0 and row increments; at row V_ACTIVE-1, col H_ACTIVE-1 both wrap to 0.
REQ-024 Popped pixel with sof=1 at (col,row)!=(0,0), or sof=0 at (0,0): o_desync set, state -> RESYNC; the popped pixel is still output.
REQ-025 RESYNC: each cycle, if head exists with sof=0 it SHALL be discarded; head with sof=1 is retained; i_req outputs 0x000000 without pop or underrun.
REQ-026 RESYNC with sof=1 at head and i_frame_start -> RUN, col=row=0; i_frame_start without it stays RESYNC.
REQ-027 i_frame_start in RUN SHALL reset col=row=0; if (col,row)!=(0,0) beforehand, o_desync set and -> RESYNC.
REQ-028 i_frame_start SHALL clear o_underrun and o_desync, unless the same cycle sets them (set wins).
REQ-029 o_level SHALL reflect count after the current edge; range 0..DEPTH; wrap-around of pointers modulo DEPTH.
REQ-030 RGB SHALL hold last value when no i_req.

Reset
REQ-031 areset SHALL asynchronously force: IDLE, FIFO empty, pointers 0, col=row=0, RGB=0, o_underrun=0, o_desync=0, o_level=0, o_pix_ready=1.
REQ-032 Reset mid-frame SHALL discard all buffered pixels; release requires a fresh i_frame_start.

Verification
REQ-033 Reset, write 400 pixels (first sof=1, B=index), i_frame_start, 400 i_req: B=0x00..0x8F sequence (mod 256), one cycle after each i_req, no flags.
REQ-034 Fill FIFO to 64 with no i_req: o_pix_ready=0, o_level=64; hold valid, one i_req: exactly one write next cycle, level back to 64.
REQ-035 i_frame_start, i_req with empty FIFO: RGB=0, o_underrun=1, col advances; next i_frame_start clears it.
REQ-036 Push 5 pixels sof=0 then frame with sof=1; i_frame_start, i_req: o_desync=1, RESYNC drops 4 remaining, next i_frame_start resumes at sof pixel.
REQ-037 Assert areset with 30 pixels buffered mid-line: o_level=0, RGB=0, state IDLE immediately, i_req ignored until i_frame_start.
REQ-038 Pop and write simultaneously at level 1 for 100 cycles: o_level stays 1, data order preserved.
